// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i write-back path: source selects, load encodings and stage states.
package rv32i_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int RF_ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        WB_ALU   = 3'd0,
        WB_IMM   = 3'd1,
        WB_PCIMM = 3'd2,
        WB_PCRET = 3'd3,
        WB_LSU   = 3'd4
    } wb_op_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_e;

    // A destination is only worth writing when enabled and not the hardwired zero register.
    function automatic logic rd_live(input logic wen, input logic [RF_ADDR_W_DEF-1:0] addr);
        return wen & (addr != {RF_ADDR_W_DEF{1'b0}});
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load data extraction: picks the byte/half/word at the offset and extends it.
module load_aligner
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [XLEN-1:0] shifted_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;

    assign shifted_s = rdata >> {addr_lo, 3'b000};
    assign byte_s    = shifted_s[7:0];
    assign half_s    = shifted_s[15:0];

    // Select width and extension; misaligned halves/words and reserved encodings are illegal.
    always_comb begin
        data    = {XLEN{1'b0}};
        illegal = 1'b0;
        case (load_f3_e'(funct3))
            LD_LB:  data = {{(XLEN-8){byte_s[7]}}, byte_s};
            LD_LBU: data = {{(XLEN-8){1'b0}}, byte_s};
            LD_LH: begin
                data    = {{(XLEN-16){half_s[15]}}, half_s};
                illegal = addr_lo[0];
            end
            LD_LHU: begin
                data    = {{(XLEN-16){1'b0}}, half_s};
                illegal = addr_lo[0];
            end
            LD_LW: begin
                data    = rdata;
                illegal = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered write-back stage: source select, load wait with timeout, RF write port and hazard flag.
module writeback_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RF_ADDR_W    = 5,
    parameter int LSU_WAIT_MAX = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ex_valid,
    output logic                 o_ex_ready,
    input  logic [2:0]           i_ex_wb_op,
    input  logic                 i_ex_rd_wen,
    input  logic [RF_ADDR_W-1:0] i_ex_rd_addr,
    input  logic [XLEN-1:0]      i_ex_alu_res,
    input  logic [XLEN-1:0]      i_ex_imm,
    input  logic [XLEN-1:0]      i_ex_pc_imm,
    input  logic [XLEN-1:0]      i_ex_pc_ret,
    input  logic [2:0]           i_ex_ld_funct3,
    input  logic [1:0]           i_ex_ld_addr_lo,
    input  logic                 i_lsu_rvalid,
    input  logic [XLEN-1:0]      i_lsu_rdata,
    input  logic                 i_lsu_rerr,
    output logic                 o_rf_rd_wen,
    output logic [RF_ADDR_W-1:0] o_rf_rd_addr,
    output logic [XLEN-1:0]      o_rf_rd_wdata,
    output logic                 o_pend_valid,
    output logic [RF_ADDR_W-1:0] o_pend_rd,
    output logic                 o_retire,
    output logic                 o_wb_err
);

    localparam int                   CNT_W    = (LSU_WAIT_MAX < 2) ? 1 : $clog2(LSU_WAIT_MAX);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LSU_WAIT_MAX - 1);
    localparam logic [RF_ADDR_W-1:0] RD_ZERO  = {RF_ADDR_W{1'b0}};

    wb_state_e            state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [RF_ADDR_W-1:0] ld_rd_r, ld_rd_s;
    logic                 ld_wen_r, ld_wen_s;
    logic [2:0]           ld_f3_r, ld_f3_s;
    logic [1:0]           ld_lo_r, ld_lo_s;

    logic                 wen_r, wen_s;
    logic [RF_ADDR_W-1:0] addr_r, addr_s;
    logic [XLEN-1:0]      data_r, data_s;
    logic                 retire_r, retire_s;
    logic                 err_r, err_s;

    logic                 fire_s;
    logic [XLEN-1:0]      src_s;
    logic [XLEN-1:0]      al_data_s;
    logic                 al_illegal_s;

    assign o_ex_ready    = (state_r == ST_IDLE);
    assign fire_s        = i_ex_valid & o_ex_ready;
    assign o_rf_rd_wen   = wen_r;
    assign o_rf_rd_addr  = addr_r;
    assign o_rf_rd_wdata = data_r;
    assign o_retire      = retire_r;
    assign o_wb_err      = err_r;
    assign o_pend_valid  = (state_r == ST_LOAD_WAIT) & ld_wen_r & (ld_rd_r != RD_ZERO);
    assign o_pend_rd     = ld_rd_r;

    load_aligner #(.XLEN(XLEN)) u_load_aligner (
        .rdata   (i_lsu_rdata),
        .funct3  (ld_f3_r),
        .addr_lo (ld_lo_r),
        .data    (al_data_s),
        .illegal (al_illegal_s)
    );

    // Non-load write data source select.
    always_comb begin
        src_s = i_ex_alu_res;
        case (wb_op_e'(i_ex_wb_op))
            WB_ALU:   src_s = i_ex_alu_res;
            WB_IMM:   src_s = i_ex_imm;
            WB_PCIMM: src_s = i_ex_pc_imm;
            WB_PCRET: src_s = i_ex_pc_ret;
            default:  src_s = i_ex_alu_res;
        endcase
    end

    // Next state, load context and next values of the registered outputs.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        ld_rd_s  = ld_rd_r;
        ld_wen_s = ld_wen_r;
        ld_f3_s  = ld_f3_r;
        ld_lo_s  = ld_lo_r;
        wen_s    = 1'b0;
        addr_s   = addr_r;
        data_s   = data_r;
        retire_s = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fire_s) begin
                    case (wb_op_e'(i_ex_wb_op))
                        WB_ALU, WB_IMM, WB_PCIMM, WB_PCRET: begin
                            retire_s = 1'b1;
                            if (i_ex_rd_wen && (i_ex_rd_addr != RD_ZERO)) begin
                                wen_s  = 1'b1;
                                addr_s = i_ex_rd_addr;
                                data_s = src_s;
                            end else begin
                                wen_s = 1'b0;
                            end
                        end
                        WB_LSU: begin
                            state_s  = ST_LOAD_WAIT;
                            cnt_s    = {CNT_W{1'b0}};
                            ld_rd_s  = i_ex_rd_addr;
                            ld_wen_s = i_ex_rd_wen;
                            ld_f3_s  = i_ex_ld_funct3;
                            ld_lo_s  = i_ex_ld_addr_lo;
                        end
                        default: err_s = 1'b1;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD_WAIT: begin
                // A response in the final wait cycle still wins over the timeout.
                if (i_lsu_rvalid) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    if (i_lsu_rerr || al_illegal_s) begin
                        err_s = 1'b1;
                    end else begin
                        retire_s = 1'b1;
                        if (ld_wen_r && (ld_rd_r != RD_ZERO)) begin
                            wen_s  = 1'b1;
                            addr_s = ld_rd_r;
                            data_s = al_data_s;
                        end else begin
                            wen_s = 1'b0;
                        end
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, load context and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            ld_rd_r  <= RD_ZERO;
            ld_wen_r <= 1'b0;
            ld_f3_r  <= 3'b000;
            ld_lo_r  <= 2'b00;
            wen_r    <= 1'b0;
            addr_r   <= RD_ZERO;
            data_r   <= {XLEN{1'b0}};
            retire_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            ld_rd_r  <= ld_rd_s;
            ld_wen_r <= ld_wen_s;
            ld_f3_r  <= ld_f3_s;
            ld_lo_r  <= ld_lo_s;
            wen_r    <= wen_s;
            addr_r   <= addr_s;
            data_r   <= data_s;
            retire_r <= retire_s;
            err_r    <= err_s;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized ops against a reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_wb_op;
    logic        ex_rd_wen;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_alu_res, ex_imm, ex_pc_imm, ex_pc_ret;
    logic [2:0]  ex_ld_funct3;
    logic [1:0]  ex_ld_addr_lo;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_rerr;
    logic        rf_wen;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        retire;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    // Model of the RF port address/data, which only move on a write.
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .RF_ADDR_W(5), .LSU_WAIT_MAX(15)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ex_valid(ex_valid), .o_ex_ready(ex_ready), .i_ex_wb_op(ex_wb_op),
        .i_ex_rd_wen(ex_rd_wen), .i_ex_rd_addr(ex_rd_addr),
        .i_ex_alu_res(ex_alu_res), .i_ex_imm(ex_imm), .i_ex_pc_imm(ex_pc_imm), .i_ex_pc_ret(ex_pc_ret),
        .i_ex_ld_funct3(ex_ld_funct3), .i_ex_ld_addr_lo(ex_ld_addr_lo),
        .i_lsu_rvalid(lsu_rvalid), .i_lsu_rdata(lsu_rdata), .i_lsu_rerr(lsu_rerr),
        .o_rf_rd_wen(rf_wen), .o_rf_rd_addr(rf_addr), .o_rf_rd_wdata(rf_wdata),
        .o_pend_valid(pend_valid), .o_pend_rd(pend_rd), .o_retire(retire), .o_wb_err(wb_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [2:0] op, input logic wen, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] pcimm,
                            input logic [31:0] pcret, input logic [2:0] f3, input logic [1:0] lo);
        ex_valid = v; ex_wb_op = op; ex_rd_wen = wen; ex_rd_addr = rd;
        ex_alu_res = alu; ex_imm = imm; ex_pc_imm = pcimm; ex_pc_ret = pcret;
        ex_ld_funct3 = f3; ex_ld_addr_lo = lo;
    endtask

    // Expected load result from the architectural load rules.
    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w, output bit bad);
        int unsigned b, h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (8 * lo)) & 32'hFFFF;
        bad = 1'b0;
        ld_model = 32'd0;
        case (f3)
            3'b000: ld_model = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100: ld_model = b;
            3'b001: if (lo % 2 != 0) bad = 1'b1; else ld_model = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101: if (lo % 2 != 0) bad = 1'b1; else ld_model = h;
            3'b010: if (lo != 0) bad = 1'b1; else ld_model = w;
            default: bad = 1'b1;
        endcase
    endfunction

    // One non-load op (or an idle cycle when v=0), checked one cycle later.
    task automatic test_op(input string tag, input logic v, input logic [2:0] op, input logic wen,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] imm,
                           input logic [31:0] pcimm, input logic [31:0] pcret);
        logic e_wen, e_ret, e_err;
        logic [31:0] vals [4];
        vals[0] = alu; vals[1] = imm; vals[2] = pcimm; vals[3] = pcret;
        e_ret = v && (op < 3'd4);
        e_err = v && (op > 3'd4);
        e_wen = e_ret && wen && (rd != 5'd0);
        if (e_wen) begin
            m_addr = rd;
            m_data = vals[op[1:0]];
        end
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b want 1", tag, ex_ready);
        end
        drive_ex(v, op, wen, rd, alu, imm, pcimm, pcret, 3'b000, 2'b00);
        tick;
        ex_valid = 1'b0;
        checks++;
        if (rf_wen !== e_wen || retire !== e_ret || wb_err !== e_err || rf_addr !== m_addr
            || rf_wdata !== m_data || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: got wen=%b ret=%b err=%b addr=%0d data=%h pend=%b want wen=%b ret=%b err=%b addr=%0d data=%h pend=0",
                     tag, rf_wen, retire, wb_err, rf_addr, rf_wdata, pend_valid, e_wen, e_ret, e_err, m_addr, m_data);
        end
    endtask

    // Full load transaction: fire, wait 'delay' cycles, then deliver the response.
    task automatic test_load_one(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                                 input logic [4:0] rd, input logic wen, input logic [31:0] w,
                                 input int delay, input logic rerr);
        bit bad;
        logic [31:0] val;
        logic e_pend, e_wen, e_ret, e_err;
        val    = ld_model(f3, lo, w, bad);
        e_pend = wen && (rd != 5'd0);
        drive_ex(1'b1, 3'd4, wen, rd, $urandom, $urandom, $urandom, $urandom, f3, lo);
        tick;
        drive_ex(1'b0, 3'($urandom_range(0, 7)), 1'b1, 5'($urandom), $urandom, $urandom, $urandom,
                 $urandom, 3'b000, 2'b00);
        for (int i = 0; i <= delay; i++) begin
            checks++;
            if (ex_ready !== 1'b0 || pend_valid !== e_pend || (e_pend && pend_rd !== rd)
                || rf_wen !== 1'b0 || retire !== 1'b0 || wb_err !== 1'b0) begin
                errors++;
                $display("FAIL %s wait%0d: got ready=%b pend=%b prd=%0d wen=%b ret=%b err=%b want ready=0 pend=%b prd=%0d wen=0 ret=0 err=0",
                         tag, i, ex_ready, pend_valid, pend_rd, rf_wen, retire, wb_err, e_pend, rd);
            end
            if (i < delay) begin
                ex_valid = $urandom_range(0, 1);
                tick;
            end
        end
        ex_valid   = 1'b0;
        lsu_rvalid = 1'b1;
        lsu_rdata  = w;
        lsu_rerr   = rerr;
        tick;
        lsu_rvalid = 1'b0;
        lsu_rerr   = 1'b0;
        lsu_rdata  = $urandom;
        e_err = rerr || bad;
        e_ret = !e_err;
        e_wen = e_ret && e_pend;
        if (e_wen) begin
            m_addr = rd;
            m_data = val;
        end
        checks++;
        if (rf_wen !== e_wen || retire !== e_ret || wb_err !== e_err || rf_addr !== m_addr
            || rf_wdata !== m_data || ex_ready !== 1'b1 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s done: got wen=%b ret=%b err=%b addr=%0d data=%h ready=%b pend=%b want wen=%b ret=%b err=%b addr=%0d data=%h ready=1 pend=0",
                     tag, rf_wen, retire, wb_err, rf_addr, rf_wdata, ex_ready, pend_valid,
                     e_wen, e_ret, e_err, m_addr, m_data);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        checks++;
        if (rf_wen !== 1'b0 || rf_addr !== 5'd0 || rf_wdata !== 32'd0 || retire !== 1'b0
            || wb_err !== 1'b0 || pend_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got wen=%b addr=%0d data=%h ret=%b err=%b pend=%b ready=%b want all 0, ready=1",
                     rf_wen, rf_addr, rf_wdata, retire, wb_err, pend_valid, ex_ready);
        end
        m_addr = 5'd0;
        m_data = 32'd0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_nonload;
        test_op("alu_rd5", 1'b1, 3'd0, 1'b1, 5'd5, 32'h0000_1234, 32'h1, 32'h2, 32'h3);
        test_op("b2b_imm", 1'b1, 3'd1, 1'b1, 5'd1, 32'h5, 32'hABCD_0000, 32'h7, 32'h8);
        test_op("b2b_pcret", 1'b1, 3'd3, 1'b1, 5'd2, 32'h9, 32'hA, 32'hB, 32'h0000_0104);
        test_op("pcimm", 1'b1, 3'd2, 1'b1, 5'd31, 32'h9, 32'hA, 32'hCAFE_F00D, 32'h1);
        test_op("idle", 1'b0, 3'd0, 1'b1, 5'd9, 32'h1, 32'h2, 32'h3, 32'h4);
        test_op("x0_alu", 1'b1, 3'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h2, 32'h3, 32'h4);
        test_op("op6", 1'b1, 3'd6, 1'b1, 5'd12, 32'h1, 32'h2, 32'h3, 32'h4);
        test_op("nowen", 1'b1, 3'd1, 1'b0, 5'd12, 32'h1, 32'h2, 32'h3, 32'h4);
    endtask

    task automatic test_loads;
        test_load_one("lb_lo3", 3'b000, 2'd3, 5'd9, 1'b1, 32'h80FF_FF01, 3, 1'b0);
        test_load_one("lhu_lo2", 3'b101, 2'd2, 5'd10, 1'b1, 32'hBEEF_0000, 1, 1'b0);
        test_load_one("lh_lo1", 3'b001, 2'd1, 5'd11, 1'b1, 32'h1234_5678, 0, 1'b0);
        test_load_one("lw_rerr", 3'b010, 2'd0, 5'd12, 1'b1, 32'h1111_2222, 2, 1'b1);
        test_load_one("lw_last", 3'b010, 2'd0, 5'd13, 1'b1, 32'h7654_3210, 14, 1'b0);
    endtask

    task automatic test_timeout;
        drive_ex(1'b1, 3'd4, 1'b1, 5'd20, 32'h0, 32'h0, 32'h0, 32'h0, 3'b010, 2'b00);
        tick;
        ex_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick;
            checks++;
            if (wb_err !== 1'b0 || ex_ready !== 1'b0 || pend_valid !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait%0d: got err=%b ready=%b pend=%b want 0 0 1", i, wb_err, ex_ready, pend_valid);
            end
        end
        tick;
        checks++;
        if (wb_err !== 1'b1 || rf_wen !== 1'b0 || retire !== 1'b0 || ex_ready !== 1'b1 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: got err=%b wen=%b ret=%b ready=%b pend=%b want 1 0 0 1 0",
                     wb_err, rf_wen, retire, ex_ready, pend_valid);
        end
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'hFFFF_FFFF;
        tick;
        lsu_rvalid = 1'b0;
        checks++;
        if (wb_err !== 1'b0 || rf_wen !== 1'b0 || retire !== 1'b0 || rf_addr !== m_addr || rf_wdata !== m_data) begin
            errors++;
            $display("FAIL late_rvalid: got err=%b wen=%b ret=%b addr=%0d data=%h want 0 0 0 %0d %h",
                     wb_err, rf_wen, retire, rf_addr, rf_wdata, m_addr, m_data);
        end
    endtask

    task automatic test_reset_in_wait;
        drive_ex(1'b1, 3'd4, 1'b1, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0, 3'b010, 2'b00);
        tick;
        ex_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ex_ready !== 1'b1 || pend_valid !== 1'b0 || rf_wen !== 1'b0 || rf_addr !== 5'd0
            || rf_wdata !== 32'd0 || retire !== 1'b0 || wb_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_wait: got ready=%b pend=%b wen=%b addr=%0d data=%h ret=%b err=%b want 1 0 0 0 0 0 0",
                     ex_ready, pend_valid, rf_wen, rf_addr, rf_wdata, retire, wb_err);
        end
        m_addr = 5'd0;
        m_data = 32'd0;
        rst = 1'b0;
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h1357_9BDF;
        tick;
        lsu_rvalid = 1'b0;
        checks++;
        if (rf_wen !== 1'b0 || wb_err !== 1'b0 || retire !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_rst: got wen=%b err=%b ret=%b ready=%b want 0 0 0 1", rf_wen, wb_err, retire, ex_ready);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                test_load_one("rnd_load", 3'($urandom_range(0, 7)), 2'($urandom), 5'($urandom_range(0, 31)),
                              1'($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 6),
                              1'($urandom_range(0, 7) == 0));
            end else begin
                logic [2:0] op;
                op = 3'($urandom_range(0, 6));
                if (op == 3'd4) op = 3'd7;
                test_op("rnd_op", 1'($urandom_range(0, 4) != 0), op, 1'($urandom_range(0, 3) != 0),
                        5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        lsu_rvalid = 1'b0;
        lsu_rdata  = 32'd0;
        lsu_rerr   = 1'b0;
        drive_ex(1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 2'b00);
        test_reset;
        test_nonload;
        test_loads;
        test_timeout;
        test_load_one("rerr_after_to", 3'b000, 2'd1, 5'd3, 1'b1, 32'hAAAA_5555, 1, 1'b1);
        test_random;
        test_reset_in_wait;
        test_nonload;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on simulation time in case the clocking ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
